opl3_timer_ctrl: RTL

Owns the OPL3 timer register set: Timer 1 preset, Timer 2 preset, and the control register 0x04 (IRQ reset, masks, starts). Sequences two 8-bit up-counters: T1 ticks every 80 us and T2 every 320 us. Maintains the status byte (IRQ, FT1, FT2) read by the host bus. Emits per-timer overflow pulses for CSM key-on logic. Sits between the host register decoder and the channel/IRQ logic.

---
 rtl/opl3_timer_ctrl_pkg.sv | 24 ++
 rtl/opl3_timer_chan.sv | 49 ++++
 rtl/opl3_timer_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/opl3_timer_ctrl_pkg.sv
// Shared definitions for the OPL3 timer block: register widths, control/status
// bit positions and the register-select encoding.
package opl3_timer_ctrl_pkg;

  localparam int REG_TIMER_WIDTH = 8;

  localparam int CTL_IRQ_RST = 7;
  localparam int CTL_MASK1   = 6;
  localparam int CTL_MASK2   = 5;
  localparam int CTL_ST2     = 1;
  localparam int CTL_ST1     = 0;

  localparam int STAT_IRQ = 7;
  localparam int STAT_FT1 = 6;
  localparam int STAT_FT2 = 5;

  typedef enum logic [1:0] {
    SEL_T1_PRESET = 2'd0,
    SEL_T2_PRESET = 2'd1,
    SEL_CONTROL   = 2'd2,
    SEL_NONE      = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/opl3_timer_chan.sv
// One OPL3 timer channel: prescaler of P clocks feeding an 8-bit up-counter
// that reloads from its preset and pulses on overflow.
module opl3_timer_chan
  import opl3_timer_ctrl_pkg::*;
#(
  parameter int P  = 10,
  parameter int PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       run,
  input  logic [REG_TIMER_WIDTH-1:0] preset,
  output logic                       ovf_now,
  output logic                       overflow_pulse
);

  localparam logic [PW-1:0] P_LAST = PW'(P - 1);

  logic [PW-1:0]              presc;
  logic [REG_TIMER_WIDTH-1:0] cnt;
  logic                       tick;

  // run is low on the edge of a stop write, so a coincident tick is dropped
  assign tick    = run && (presc == P_LAST);
  assign ovf_now = tick && (cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc          <= '0;
      cnt            <= '0;
      overflow_pulse <= 1'b0;
    end else begin
      overflow_pulse <= ovf_now;
      if (start) begin
        presc <= '0;
        cnt   <= preset;
      end else if (run) begin
        if (tick) begin
          presc <= '0;
          cnt   <= (cnt == '1) ? preset : cnt + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/opl3_timer_ctrl.sv
// OPL3 timer register set and status byte; owns presets, ST/MASK bits and the
// FT1/FT2 flags, and drives two timer channels.
module opl3_timer_ctrl
  import opl3_timer_ctrl_pkg::*;
#(
  parameter int TICK_CLKS = 1000,
  parameter int T2_DIV    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reg_wr,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  output logic [7:0] status,
  output logic       irq,
  output logic       t1_overflow_pulse,
  output logic       t2_overflow_pulse
);

  localparam int P1 = TICK_CLKS;
  localparam int P2 = T2_DIV * TICK_CLKS;
  localparam int PW = (P2 > 1) ? $clog2(P2) : 1;

  reg_sel_e                   sel;
  logic [REG_TIMER_WIDTH-1:0] preset1, preset2;
  logic                       st1, st2, mask1, mask2, ft1, ft2;
  logic                       ctl_wr, irq_rst, ctl_set;
  logic                       st1_nxt, st2_nxt;
  logic                       start1, start2, run1, run2;
  logic                       ovf1_now, ovf2_now;
  logic                       ctl_unused;

  assign sel        = reg_sel_e'(reg_sel);
  assign ctl_wr     = reg_wr && (sel == SEL_CONTROL);
  assign irq_rst    = ctl_wr && reg_data[CTL_IRQ_RST];
  assign ctl_set    = ctl_wr && !reg_data[CTL_IRQ_RST];
  assign ctl_unused = ^reg_data[4:2];

  assign st1_nxt = ctl_set ? reg_data[CTL_ST1] : st1;
  assign st2_nxt = ctl_set ? reg_data[CTL_ST2] : st2;

  // Only a 0->1 transition reloads; a 1->1 rewrite leaves the phase alone
  assign start1 = st1_nxt && !st1;
  assign start2 = st2_nxt && !st2;
  assign run1   = st1 && st1_nxt;
  assign run2   = st2 && st2_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset1 <= '0;
      preset2 <= '0;
      st1     <= 1'b0;
      st2     <= 1'b0;
      mask1   <= 1'b0;
      mask2   <= 1'b0;
      ft1     <= 1'b0;
      ft2     <= 1'b0;
    end else begin
      if (reg_wr && (sel == SEL_T1_PRESET)) preset1 <= reg_data;
      if (reg_wr && (sel == SEL_T2_PRESET)) preset2 <= reg_data;
      if (ctl_set) begin
        mask1 <= reg_data[CTL_MASK1];
        mask2 <= reg_data[CTL_MASK2];
      end
      st1 <= st1_nxt;
      st2 <= st2_nxt;
      // A flag set on the same edge as IRQ_RST wins
      if (ovf1_now && !mask1) ft1 <= 1'b1;
      else if (irq_rst)       ft1 <= 1'b0;
      if (ovf2_now && !mask2) ft2 <= 1'b1;
      else if (irq_rst)       ft2 <= 1'b0;
    end
  end

  always_comb begin
    status           = '0;
    status[STAT_IRQ] = ft1 | ft2;
    status[STAT_FT1] = ft1;
    status[STAT_FT2] = ft2;
  end

  assign irq = status[STAT_IRQ];

  opl3_timer_chan #(.P(P1), .PW(PW)) u_t1 (
    .clk            (clk),
    .rst            (reset),
    .start          (start1),
    .run            (run1),
    .preset         (preset1),
    .ovf_now        (ovf1_now),
    .overflow_pulse (t1_overflow_pulse)
  );

  opl3_timer_chan #(.P(P2), .PW(PW)) u_t2 (
    .clk            (clk),
    .rst            (reset),
    .start          (start2),
    .run            (run2),
    .preset         (preset2),
    .ovf_now        (ovf2_now),
    .overflow_pulse (t2_overflow_pulse)
  );

endmodule
